// File: rtl/prbs_checker.sv
// prbs_checker: receive-side PRBS-7 / PRBS-13 checker.
//
// It locks a local LFSR to the incoming serial stream without help from the sender. After lock it
// predicts every following bit and counts checked bits and mismatches for BER measurement.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high; clears all state
//   control       polynomial select: 1 = PRBS-7 (x^7+x^6+1), 0 = PRBS-13 (x^13+x^12+x^2+x+1)
//   rx_valid      rx_bit is valid this cycle
//   rx_bit        received serial bit
//   clear_counts  synchronous clear of bit_count / error_count (wins over increment)
//   locked        checker is in the LOCKED state
//   error_pulse   one-cycle pulse: previous valid bit mismatched while LOCKED
//   lock_lost     one-cycle pulse on the LOCKED -> SEED transition
//   bit_count     saturating count of bits checked while LOCKED
//   error_count   saturating count of mismatched bits while LOCKED
//
// Build option
//   CHECKER_LOS_EN  when defined, too many errors inside one WIN_LEN-bit window drop lock.
//                   When undefined, only reset or a control change leaves LOCKED.
module prbs_checker #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned VERIFY_LEN  = 16,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             control,
    input  logic             rx_valid,
    input  logic             rx_bit,
    input  logic             clear_counts,
    output logic             locked,
    output logic             error_pulse,
    output logic             lock_lost,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] error_count
);

    typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

    state_e           state_q, state_d;
    logic [12:0]      hist_q, hist_d;
    logic [3:0]       seed_cnt_q, seed_cnt_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;
    logic             ctrl_q;
    logic             locked_q, locked_d;
    logic             error_pulse_q, error_pulse_d;
    logic             lock_lost_q, lock_lost_d;

    logic             pred;
    logic [3:0]       order;
    logic             mismatch;
    logic             ctrl_change;
    logic             check_en;
    logic             los_hit;

    // The polynomial follows the registered control. On the edge where control changes, the
    // checker is forced to SEED anyway, so the stale prediction is never used.
    assign pred        = ctrl_q ? (hist_q[6] ^ hist_q[5])
                                : (hist_q[12] ^ hist_q[11] ^ hist_q[1] ^ hist_q[0]);
    assign order       = ctrl_q ? 4'd7 : 4'd13;
    assign mismatch    = rx_bit ^ pred;
    assign ctrl_change = (ctrl_q != control);
    // A control change wins over checking, so the counters stay untouched on that edge.
    assign check_en    = rx_valid && (state_q == StLocked) && !ctrl_change;

`ifdef CHECKER_LOS_EN
    localparam int unsigned WinW = $clog2(WIN_LEN);
    localparam int unsigned ErrW = $clog2(LOSS_THRESH + 1);

    logic [WinW-1:0] win_cnt_q, win_cnt_d;
    logic [ErrW-1:0] win_err_q, win_err_d;
    logic [ErrW-1:0] win_err_inc;

    assign win_err_inc = win_err_q + ErrW'(mismatch);
    assign los_hit     = check_en && (win_err_inc == ErrW'(LOSS_THRESH));

    always_comb begin
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        if (state_d == StLocked && state_q != StLocked) begin
            win_cnt_d = '0;
            win_err_d = '0;
        end else if (check_en && !los_hit) begin
            // WIN_LEN is a power of two, so the bit counter wraps on its own.
            win_cnt_d = win_cnt_q + WinW'(1);
            win_err_d = (win_cnt_q == WinW'(WIN_LEN - 1)) ? '0 : win_err_inc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
        end
    end
`else
    assign los_hit = 1'b0;
    // The window parameters have no effect in this build.
    logic unused_win_cfg;
    assign unused_win_cfg = ^{WIN_LEN[0], LOSS_THRESH[0]};
`endif

    // State register plus all datapath flops.
    always_ff @(posedge clock) begin
        ctrl_q <= control;
        if (reset) begin
            state_q       <= StSeed;
            hist_q        <= '0;
            seed_cnt_q    <= '0;
            match_cnt_q   <= '0;
            bit_count_q   <= '0;
            error_count_q <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hist_q        <= hist_d;
            seed_cnt_q    <= seed_cnt_d;
            match_cnt_q   <= match_cnt_d;
            bit_count_q   <= bit_count_d;
            error_count_q <= error_count_d;
            locked_q      <= locked_d;
            error_pulse_q <= error_pulse_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (ctrl_change) begin
            state_d = StSeed;
        end else if (rx_valid) begin
            case (state_q)
                StSeed:   if (seed_cnt_q == order - 4'd1) state_d = StVerify;
                StVerify: begin
                    if (mismatch)                                   state_d = StSeed;
                    else if (match_cnt_q == 8'(VERIFY_LEN - 1))     state_d = StLocked;
                end
                StLocked: if (los_hit) state_d = StSeed;
                default:  state_d = StSeed;
            endcase
        end
    end

    // Datapath next values.
    always_comb begin
        hist_d = hist_q;
        if (rx_valid && !ctrl_change) begin
            // Once locked, the LFSR free-runs on its own prediction so a line error is counted once.
            hist_d = {hist_q[11:0], (state_q == StLocked) ? pred : rx_bit};
        end

        seed_cnt_d = '0;
        if (state_q == StSeed && state_d == StSeed && !ctrl_change) begin
            seed_cnt_d = rx_valid ? seed_cnt_q + 4'd1 : seed_cnt_q;
        end

        match_cnt_d = '0;
        if (state_q == StVerify && state_d == StVerify) begin
            match_cnt_d = rx_valid ? match_cnt_q + 8'd1 : match_cnt_q;
        end

        bit_count_d = bit_count_q;
        if (clear_counts) begin
            bit_count_d = '0;
        end else if (check_en && bit_count_q != '1) begin
            bit_count_d = bit_count_q + CNT_W'(1);
        end

        error_count_d = error_count_q;
        if (clear_counts) begin
            error_count_d = '0;
        end else if (check_en && mismatch && error_count_q != '1) begin
            error_count_d = error_count_q + CNT_W'(1);
        end
    end

    // Output logic (registered above).
    always_comb begin
        locked_d      = (state_d == StLocked);
        error_pulse_d = check_en && mismatch;
        lock_lost_d   = (state_q == StLocked) && (state_d == StSeed);
    end

    assign locked      = locked_q;
    assign error_pulse = error_pulse_q;
    assign lock_lost   = lock_lost_q;
    assign bit_count   = bit_count_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker. It drives two instances from one stream: a default build and a
// CNT_W=4 build for saturation. The bench's own stream generator defines the expected bits.
module tb_prbs_checker;

    logic        clock = 1'b0;
    logic        reset;
    logic        control;
    logic        rx_valid;
    logic        rx_bit;
    logic        clear_counts;

    logic        locked, error_pulse, lock_lost;
    logic [31:0] bit_count, error_count;
    logic        s_locked, s_error_pulse, s_lock_lost;
    logic [3:0]  s_bit_count, s_error_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned pulses = 0;
    int unsigned losts = 0;

    // Stream generator state; g[0] is the most recently sent bit.
    logic [12:0] g;
    logic        poly7;

    always #5 clock = ~clock;

    prbs_checker u_dut (
        .clock        (clock),
        .reset        (reset),
        .control      (control),
        .rx_valid     (rx_valid),
        .rx_bit       (rx_bit),
        .clear_counts (clear_counts),
        .locked       (locked),
        .error_pulse  (error_pulse),
        .lock_lost    (lock_lost),
        .bit_count    (bit_count),
        .error_count  (error_count)
    );

    prbs_checker #(
        .CNT_W       (4),
        .LOSS_THRESH (64)
    ) u_sat (
        .clock        (clock),
        .reset        (reset),
        .control      (control),
        .rx_valid     (rx_valid),
        .rx_bit       (rx_bit),
        .clear_counts (clear_counts),
        .locked       (s_locked),
        .error_pulse  (s_error_pulse),
        .lock_lost    (s_lock_lost),
        .bit_count    (s_bit_count),
        .error_count  (s_error_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_bit(output logic b);
        b = poly7 ? (g[6] ^ g[5]) : (g[12] ^ g[11] ^ g[1] ^ g[0]);
        g = {g[11:0], b};
    endtask

    task automatic send(input logic v, input logic b, input logic clr);
        rx_valid     = v;
        rx_bit       = b;
        clear_counts = clr;
        @(posedge clock);
        #1;
        if (error_pulse) pulses++;
        if (lock_lost)   losts++;
        rx_valid     = 1'b0;
        clear_counts = 1'b0;
    endtask

    task automatic send_good(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_bit(b);
            send(1'b1, b, 1'b0);
        end
    endtask

    task automatic send_err(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_bit(b);
            send(1'b1, ~b, 1'b0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        control      = 1'b1;
        rx_valid     = 1'b0;
        rx_bit       = 1'b0;
        clear_counts = 1'b0;
        g            = 13'h0001;
        poly7        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state.
        check_val("rst_locked", {31'd0, locked}, 32'd0);
        check_val("rst_err_pulse", {31'd0, error_pulse}, 32'd0);
        check_val("rst_lock_lost", {31'd0, lock_lost}, 32'd0);
        check_val("rst_bit_count", bit_count, 32'd0);
        check_val("rst_error_count", error_count, 32'd0);

        // PRBS-7 clean: lock exactly on the 23rd valid bit, then 1000 clean bits.
        send_good(22);
        check_val("p7_not_locked_22", {31'd0, locked}, 32'd0);
        send_good(1);
        check_val("p7_locked_23", {31'd0, locked}, 32'd1);
        check_val("p7_bits_at_lock", bit_count, 32'd0);
        send_good(1000);
        check_val("p7_bit_count", bit_count, 32'd1000);
        check_val("p7_error_count", error_count, 32'd0);
        check_val("p7_pulses", pulses, 32'd0);

        // Idle gaps: 100 valid bits interleaved with 100 idle cycles.
        for (int i = 0; i < 100; i++) begin
            send_good(1);
            send(1'b0, 1'b0, 1'b0);
        end
        check_val("gap_bit_count", bit_count, 32'd1100);
        check_val("gap_error_count", error_count, 32'd0);
        check_val("gap_locked", {31'd0, locked}, 32'd1);

        // Control switch to PRBS-13 on an idle cycle; relock after 13+16 bits, counters kept.
        control = 1'b0;
        send(1'b0, 1'b0, 1'b0);
        check_val("sw_lock_lost", {31'd0, lock_lost}, 32'd1);
        check_val("sw_locked", {31'd0, locked}, 32'd0);
        poly7 = 1'b0;
        send_good(28);
        check_val("p13_not_locked_28", {31'd0, locked}, 32'd0);
        send_good(1);
        check_val("p13_locked_29", {31'd0, locked}, 32'd1);
        check_val("sw_bit_count", bit_count, 32'd1100);
        check_val("sw_error_count", error_count, 32'd0);

        // PRBS-13 single error: counted once, no multiplication, lock held.
        pulses = 0;
        send_good(50);
        send_err(1);
        check_val("se_pulse", {31'd0, error_pulse}, 32'd1);
        check_val("se_error_count", error_count, 32'd1);
        check_val("se_bit_count", bit_count, 32'd1151);
        send_good(100);
        check_val("se_pulses", pulses, 32'd1);
        check_val("se_error_count_after", error_count, 32'd1);
        check_val("se_locked", {31'd0, locked}, 32'd1);

        // Eight errors in one window.
        send(1'b0, 1'b0, 1'b1);
        check_val("clr_bit_count", bit_count, 32'd0);
        check_val("clr_error_count", error_count, 32'd0);
        losts = 0;
        send_err(7);
        check_val("los_locked_7", {31'd0, locked}, 32'd1);
        send_err(1);
        check_val("los_error_count", error_count, 32'd8);
        check_val("los_pulse", {31'd0, error_pulse}, 32'd1);
`ifdef CHECKER_LOS_EN
        check_val("los_lock_lost", {31'd0, lock_lost}, 32'd1);
        check_val("los_locked", {31'd0, locked}, 32'd0);
        send_good(28);
        check_val("los_relock_28", {31'd0, locked}, 32'd0);
        send_good(1);
        check_val("los_relock_29", {31'd0, locked}, 32'd1);
        check_val("los_losts", losts, 32'd1);
`else
        check_val("nolos_lock_lost", {31'd0, lock_lost}, 32'd0);
        check_val("nolos_locked", {31'd0, locked}, 32'd1);
        send_good(29);
        check_val("nolos_locked_after", {31'd0, locked}, 32'd1);
        check_val("nolos_losts", losts, 32'd0);
`endif
        check_val("los_error_count_after", error_count, 32'd8);

        // Reset overrides clear_counts and a control change.
        reset   = 1'b1;
        control = 1'b1;
        send(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        check_val("mid_rst_bit_count", bit_count, 32'd0);
        check_val("mid_rst_error_count", error_count, 32'd0);
        check_val("mid_rst_locked", {31'd0, locked}, 32'd0);

        // Saturation on the 4-bit instance, then clear_counts beating an errored bit.
        poly7 = 1'b1;
        send_good(23);
        check_val("sat_locked", {31'd0, s_locked}, 32'd1);
        send_err(20);
        check_val("sat_error_count", {28'd0, s_error_count}, 32'd15);
        check_val("sat_bit_count", {28'd0, s_bit_count}, 32'd15);
        check_val("sat_locked_after", {31'd0, s_locked}, 32'd1);
        begin
            logic b;
            next_bit(b);
            send(1'b1, ~b, 1'b1);
        end
        check_val("sat_clr_error_count", {28'd0, s_error_count}, 32'd0);
        check_val("sat_clr_bit_count", {28'd0, s_bit_count}, 32'd0);
        check_val("sat_clr_pulse", {31'd0, s_error_pulse}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
